// File: rtl/node_mem_arbiter_pkg.sv
// node_mem_arbiter_pkg: octant node word field layout and node memory arbiter state encoding.
package node_mem_arbiter_pkg;
  localparam int NODE_PTR_MSB = 31;
  localparam int NODE_PTR_LSB = 16;
  localparam int NODE_LEAF_MSB = 15;
  localparam int NODE_LEAF_LSB = 8;
  localparam int NODE_BRANCH_MSB = 7;
  localparam int NODE_BRANCH_LSB = 0;
  typedef enum logic {ARB, CLEAR} arb_state_t;
endpackage

// File: rtl/node_mem_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from a pointer that advances past each winner.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  localparam int JW = IW + 1;
  logic [IW-1:0] ptr;
  logic [JW-1:0] j;
  logic any;
  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + JW'(k);
      j = (j >= JW'(N)) ? j - JW'(N) : j;
      if (en && req[j[IW-1:0]]) begin
        idx = j[IW-1:0];
        any = 1'b1;
      end
    end
  end
  assign grant = any ? N'(1) << idx : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (any) ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/node_mem_arbiter.sv
// node_mem_arbiter: round-robin sharing of the octree node BRAM with read-response routing.
// NODE_ARB_CLEAR_EN enables the sweep that zeroes every node before a new frame.
module node_mem_arbiter
  import node_mem_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int NUM_REQ = 2,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ-1:0]       i_req_we,
  input  logic [NUM_REQ*ADDRW-1:0] i_req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]         o_rsp_data,
  output logic                     o_mem_we,
  output logic [ADDRW-1:0]         o_mem_addr_write,
  output logic [ADDRW-1:0]         o_mem_addr_read,
  output logic [WIDTH-1:0]         o_mem_data_in,
  input  logic [WIDTH-1:0]         i_mem_data_out,
  input  logic                     i_clear,
  output logic                     o_busy
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] idx;
  logic en, clearing, granted;
  logic [ADDRW-1:0] cnt, last_addr;
  logic [WIDTH-1:0] last_data;
`ifdef NODE_ARB_CLEAR_EN
  arb_state_t state;
  logic busy;
  assign clearing = state == CLEAR;
  assign en = !i_rst && !clearing && !i_clear;
  assign o_busy = busy;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= ARB;
      cnt <= '0;
      busy <= 1'b0;
    end else if (state == ARB) begin
      state <= i_clear ? CLEAR : ARB;
      busy <= i_clear;
    end else begin
      cnt <= (cnt == ADDRW'(DEPTH - 1)) ? '0 : cnt + 1'b1;
      state <= (cnt == ADDRW'(DEPTH - 1)) ? ARB : CLEAR;
      busy <= cnt != ADDRW'(DEPTH - 1);
    end
`else
  logic unused_clear;
  assign unused_clear = i_clear;
  assign clearing = 1'b0;
  assign cnt = '0;
  assign en = !i_rst;
  assign o_busy = 1'b0;
`endif
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk(i_clk),
    .rst(i_rst),
    .req(i_req_valid),
    .en(en),
    .grant(o_req_ready),
    .idx(idx)
  );
  assign granted = |o_req_ready;
  // Idle cycles keep the last address and data on the BRAM ports.
  assign o_mem_we = clearing | (granted & i_req_we[idx]);
  assign o_mem_addr_write = clearing ? cnt : granted ? i_req_addr[idx*ADDRW +: ADDRW] : last_addr;
  assign o_mem_addr_read = o_mem_addr_write;
  assign o_mem_data_in = clearing ? '0 : granted ? i_req_wdata[idx*WIDTH +: WIDTH] : last_data;
  assign o_rsp_data = i_mem_data_out;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      last_addr <= '0;
      last_data <= '0;
      o_rsp_valid <= '0;
    end else begin
      last_addr <= o_mem_addr_write;
      last_data <= o_mem_data_in;
      o_rsp_valid <= o_req_ready & ~i_req_we;
    end
endmodule

// File: tb/tb_node_mem_arbiter.sv
// tb_node_mem_arbiter: directed stimulus with a per-cycle behavioural model of arbitration, memory and clear.
module tb_node_mem_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int NUM_REQ = 2;
  localparam int ADDRW = $clog2(DEPTH);
`ifdef NODE_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  logic clk, rst, clr, busy, mem_we;
  logic [NUM_REQ-1:0] valid, ready, rwe, rsp_valid;
  logic [NUM_REQ-1:0][ADDRW-1:0] ra;
  logic [NUM_REQ-1:0][WIDTH-1:0] wd;
  logic [WIDTH-1:0] rsp_data, mdi, mdo;
  logic [ADDRW-1:0] maw, mar;
  logic [WIDTH-1:0] bram [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  int checks = 0;
  int errors = 0;

  node_mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready), .i_req_we(rwe),
    .i_req_addr(ra), .i_req_wdata(wd), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_mem_we(mem_we), .o_mem_addr_write(maw), .o_mem_addr_read(mar), .o_mem_data_in(mdi),
    .i_mem_data_out(mdo), .i_clear(clr), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) bram[maw] <= mdi;
    mdo <= bram[mar];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model state: rotating priority, sweep progress, expected response and idle address.
  int ptr = 0;
  int clr_left = 0;
  int clr_addr = 0;
  logic [NUM_REQ-1:0] exp_rv = '0;
  logic [WIDTH-1:0] exp_rd = '0;
  logic [ADDRW-1:0] last_addr = '0;

  always @(negedge clk) begin
    int g, j;
    bit gv;
    if (rst) begin
      chk("rst_ready", ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_addr_w", maw, 0);
      chk("rst_addr_r", mar, 0);
      chk("rst_data_in", mdi, 0);
      ptr = 0;
      clr_left = 0;
      clr_addr = 0;
      exp_rv = '0;
      last_addr = '0;
    end else begin
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 0) chk("rsp_data", rsp_data, exp_rd);
      chk("busy", busy, clr_left > 0);
      exp_rv = '0;
      if (clr_left > 0) begin
        chk("clr_ready", ready, 0);
        chk("clr_we", mem_we, 1);
        chk("clr_addr_w", maw, clr_addr);
        chk("clr_addr_r", mar, clr_addr);
        chk("clr_data", mdi, 0);
        shadow[clr_addr] = '0;
        last_addr = ADDRW'(clr_addr);
        clr_addr++;
        clr_left--;
      end else if (CLR_EN && clr) begin
        chk("clr_start_ready", ready, 0);
        chk("clr_start_we", mem_we, 0);
        chk("clr_start_addr", maw, last_addr);
        clr_left = DEPTH;
        clr_addr = 0;
      end else begin
        gv = 1'b0;
        g = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (ptr + k) % NUM_REQ;
          if (!gv && valid[j]) begin
            gv = 1'b1;
            g = j;
          end
        end
        chk("ready", ready, gv ? (1 << g) : 0);
        if (gv) begin
          chk("mem_we", mem_we, rwe[g]);
          chk("addr_w", maw, ra[g]);
          chk("addr_r", mar, ra[g]);
          if (rwe[g]) begin
            chk("data_in", mdi, wd[g]);
            shadow[ra[g]] = wd[g];
          end else begin
            exp_rv = NUM_REQ'(1) << g;
            exp_rd = shadow[ra[g]];
          end
          last_addr = ra[g];
          ptr = (g + 1) % NUM_REQ;
        end else begin
          chk("idle_we", mem_we, 0);
          chk("idle_addr_w", maw, last_addr);
          chk("idle_addr_r", mar, last_addr);
        end
      end
    end
  end

  task automatic xfer(input int r, input bit w, input logic [ADDRW-1:0] a, input logic [WIDTH-1:0] d, output int n);
    n = 0;
    valid[r] = 1'b1;
    rwe[r] = w;
    ra[r] = a;
    wd[r] = d;
    @(negedge clk);
    while (!ready[r] && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("xfer_wait_bound", n < 400, 1);
    @(posedge clk);
    #1 valid[r] = 1'b0;
  endtask

  task automatic rd(input int r, input logic [ADDRW-1:0] a, output logic [WIDTH-1:0] d, output int n);
    xfer(r, 1'b0, a, '0, n);
    @(negedge clk);
    d = rsp_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] gseq [4];
    logic [WIDTH-1:0] d;
    int n, busy_n;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = 32'hC0DE_0000 | WIDTH'(i);
      shadow[i] = 32'hC0DE_0000 | WIDTH'(i);
    end
    bram[5] = 32'h0012_3456;
    shadow[5] = 32'h0012_3456;
    rst = 1'b0;
    clr = 1'b0;
    valid = '0;
    rwe = '0;
    ra = '0;
    wd = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ra[0] = 8'h20;
    ra[1] = 8'h21;
    valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gseq[i] = ready;
      @(posedge clk);
      #1;
    end
    valid = '0;
    chk("cont_g0", gseq[0], 2'b01);
    chk("cont_g1", gseq[1], 2'b10);
    chk("cont_g2", gseq[2], 2'b01);
    chk("cont_g3", gseq[3], 2'b10);
    rd(0, 8'h05, d, n);
    chk("single_read_latency", n, 0);
    chk("single_read_data", d, 32'h0012_3456);
    xfer(1, 1'b1, 8'h10, 32'hABCD_0F01, n);
    rd(1, 8'h10, d, n);
    chk("wr_rd_latency", n, 0);
    chk("wr_rd_data", d, 32'hABCD_0F01);
`ifdef NODE_ARB_CLEAR_EN
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd(0, 8'd99, d, n);
    chk("midrst_addr99", d, 0);
    rd(0, 8'd100, d, n);
    chk("midrst_addr100", d, 32'hC0DE_0064);
    rd(1, 8'd255, d, n);
    chk("midrst_addr255", d, 32'hC0DE_00FF);
    valid[0] = 1'b1;
    rwe[0] = 1'b0;
    ra[0] = 8'h07;
    clr = 1'b1;
    @(negedge clk);
    chk("clr_same_cycle_ready", ready, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    busy_n = 0;
    n = 0;
    @(negedge clk);
    while (!ready[0] && n < 400) begin
      if (busy) busy_n++;
      n++;
      @(negedge clk);
    end
    chk("clr_wait_bound", n < 400, 1);
    chk("clr_busy_cycles", busy_n, 256);
    chk("clr_back_busy", busy, 0);
    @(posedge clk);
    #1 valid[0] = 1'b0;
    @(negedge clk);
    chk("clr_pending_data", rsp_data, 0);
    @(posedge clk);
    #1;
    for (int a = 0; a < DEPTH; a++) begin
      rd(a % NUM_REQ, ADDRW'(a), d, n);
      chk("clr_all_zero", d, 0);
    end
`else
    valid[0] = 1'b1;
    rwe[0] = 1'b0;
    ra[0] = 8'h07;
    clr = 1'b1;
    @(negedge clk);
    chk("noclr_ready", ready, 2'b01);
    chk("noclr_busy", busy, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    valid = '0;
    @(negedge clk);
    chk("noclr_data", rsp_data, 32'hC0DE_0007);
    @(posedge clk);
    #1;
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/node_mem_arbiter.md
# node_mem_arbiter

Shares the octree node BRAM among several requesters inside the octant core, such as the insertion engine and the readout/DMA walker. The BRAM stores one node per word: {pointer[31:16], leaf mask[15:8], branch mask[7:0]}. The arbiter grants at most one access per cycle using round-robin priority and returns read data to the requester that issued the read. It also contains an optional clear sequencer that zeroes every node before a new frame is built.

## Interface
Parameters:
- WIDTH, 32, node word width
- DEPTH, 256, number of node entries; ADDRW = $clog2(DEPTH)
- NUM_REQ, 2, number of requesters (at least 2)

Ports:
- i_clk  in  1  single clock
- i_rst  in  1  reset; asynchronous, active-high
- i_req_valid  in  NUM_REQ  request valid, one bit per requester
- o_req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- i_req_we  in  NUM_REQ  1 = write, 0 = read
- i_req_addr  in  NUM_REQ*ADDRW  packed addresses; requester i uses slice i
- i_req_wdata  in  NUM_REQ*WIDTH  packed write data
- o_rsp_valid  out  NUM_REQ  read data valid for requester i
- o_rsp_data  out  WIDTH  read data, shared by all requesters
- o_mem_we, o_mem_addr_write, o_mem_addr_read, o_mem_data_in  out  1/ADDRW/ADDRW/WIDTH  drive the BRAM ports
- i_mem_data_out  in  WIDTH  BRAM read data (registered inside the BRAM)
- i_clear  in  1  start a clear sweep (pulse)
- o_busy  out  1  clear sweep in progress

## Operation
- States: ARB and CLEAR. Reset enters ARB.
- ARB state:
  - Grant the first requester with valid set, searching from the round-robin pointer upward and wrapping.
  - o_req_ready is combinational, high only for the granted requester.
  - A transfer happens at a clock edge where valid and ready are both high.
  - After a transfer, the pointer moves to (granted + 1) mod NUM_REQ. With no transfer, the pointer holds.
- Memory drive:
  - o_mem_* are a combinational mux of the granted request.
  - o_mem_we = valid & ready & we. Write address and read address carry the same value.
  - When nothing is granted, o_mem_we = 0 and the addresses hold their last value.
- Requester rules: valid, we, addr and wdata must stay stable until the request is accepted. Dropping valid before acceptance is legal; the request is simply withdrawn.
- Read response: o_rsp_valid[i] is registered and rises the cycle after a read from requester i is accepted. o_rsp_data is passed through from i_mem_data_out. Writes produce no response.
- Clear:
  - i_clear sampled high in ARB moves the block to CLEAR.
  - In CLEAR, all o_req_ready bits are 0, o_busy = 1, and one entry is written with 0 per cycle, address 0 through DEPTH-1.
  - After writing address DEPTH-1, the block returns to ARB.
  - i_clear is ignored while in CLEAR. Pending requests wait.
  - If i_clear and a request arrive in the same ARB cycle, the clear wins and no request is accepted that cycle.
  - A read response still in flight when the clear starts is delivered normally.
- Reset at any point, including mid-sweep, returns the block to ARB: pointer = 0, clear counter = 0. Entries already cleared stay cleared.

## Timing
- Reset values: o_req_ready = 0 while i_rst is asserted, o_rsp_valid = 0, o_busy = 0, o_mem_we = 0, o_mem_addr_* = 0, o_mem_data_in = 0.
- Throughput: one access per cycle, with no bubble between back-to-back grants.
- Read latency: request accepted at edge k, data and o_rsp_valid present in cycle k+1.
- A read accepted the cycle after a write to the same address returns the new data. A same-cycle read and write cannot occur.
- Clear lasts exactly DEPTH cycles. o_busy rises the cycle after i_clear is sampled and falls after the final write.

## Configuration
- NODE_ARB_CLEAR_EN:
  - Defined: the CLEAR state, the counter and o_busy behaviour are as described above.
  - Undefined: the sweep logic is removed, i_clear is ignored, and o_busy is tied to 0.

## Structure
- Shared octant package holds:
  - The node field constants: NODE_PTR_MSB/LSB = 31/16, NODE_LEAF_MSB/LSB = 15/8, NODE_BRANCH_MSB/LSB = 7/0.
  - The state encoding (ARB, CLEAR).
- One sub-module, rr_arbiter: a parameterised NUM_REQ round-robin grant with pointer update. Everything else is flat.

## Test plan
- Single read: requester 0 reads address 0x05, which holds 0x0012_3456 -> ready in the same cycle, o_rsp_valid[0] = 1 one cycle later with data 0x0012_3456.
- Contention: both requesters valid continuously, pointer = 0 -> grants go 0, 1, 0, 1, with no idle cycles.
- Write then read: requester 1 writes 0xABCD_0F01 to address 0x10, then reads 0x10 on the next cycle -> response data 0xABCD_0F01.
- Clear: pulse i_clear with DEPTH = 256 -> o_busy high for 256 cycles, o_req_ready = 0 throughout, and every address then reads 0. A pending request is accepted on the first cycle back in ARB.
- i_clear and a request in the same cycle -> clear starts and the request is not accepted until the sweep ends.
- Reset mid-sweep at counter 100 -> o_busy = 0 immediately, addresses 0–99 are zero, address 100 and above are unchanged.
